regfile_reader: RTL and testbench

Burst readback engine for the 8-bit register file: on a start command it reads a run of consecutive registers through the file's synchronous read port and streams each byte out over a valid/ready handshake. It is the consumer end of the register write path. Writers load registers on enable; this block drains them toward the debug/output bus without stalling the datapath.

---
 rtl/regfile_reader_pkg.sv | 21 ++
 rtl/regfile_reader_sum8.sv | 17 +
 rtl/regfile_reader.sv | 138 +++++++++++++
 tb/tb_regfile_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file burst reader: state encodings and default address width.
// Optional checksum byte is enabled with REGFILE_READER_CHECKSUM_EN.
`ifndef REGFILE_READER_PKG_SV
`define REGFILE_READER_PKG_SV

package regfile_reader_pkg;

  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4,
    ST_SUM  = 3'd5
  } state_t;

endpackage

`endif

// File: rtl/regfile_reader_sum8.sv
// 8-bit clear/accumulate register used for the burst checksum.
// Instantiated only when REGFILE_READER_CHECKSUM_EN is defined.
module sum8 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clock) begin
    if (reset || clear) sum <= 8'h00;
    else if (add_en)    sum <= sum + data;
  end

endmodule

// File: rtl/regfile_reader.sv
// Burst readback engine: reads consecutive registers through a 1-cycle read port and streams them
// over valid/ready. Defining REGFILE_READER_CHECKSUM_EN appends a mod-256 sum byte to each burst.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;

  // The read port is addressed straight from the address register.
  assign rd_addr = addr;

`ifdef REGFILE_READER_CHECKSUM_EN
  logic [7:0] acc;

  sum8 u_sum8 (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_IDLE && start),
    .add_en (state == ST_SEND && out_ready),
    .data   (out),
    .sum    (acc)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      out       <= 8'h00;
      out_valid <= 1'b0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a transition below re-asserts them.
      rd_en <= 1'b0;
      done  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= base;
            remaining <= count;
            busy      <= 1'b1;
            if (count == '0) begin
`ifdef REGFILE_READER_CHECKSUM_EN
              state     <= ST_SUM;
              out       <= 8'h00;
              out_valid <= 1'b1;
`else
              state     <= ST_FIN;
              done      <= 1'b1;
`endif
            end else begin
              state <= ST_ADDR;
              rd_en <= 1'b1;
            end
          end
        end

        ST_ADDR: state <= ST_WAIT;

        ST_WAIT: begin
          out       <= rd_data;
          out_valid <= 1'b1;
          state     <= ST_SEND;
        end

        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
`ifdef REGFILE_READER_CHECKSUM_EN
              // acc has not yet absorbed the byte leaving on this edge.
              state     <= ST_SUM;
              out       <= acc + out;
              out_valid <= 1'b1;
`else
              state     <= ST_FIN;
              done      <= 1'b1;
`endif
            end else begin
              state <= ST_ADDR;
              rd_en <= 1'b1;
            end
          end
        end

`ifdef REGFILE_READER_CHECKSUM_EN
        ST_SUM: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_FIN;
            done      <= 1'b1;
          end
        end
`endif

        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader with a behavioural register file on the read port.
// Expected bytes and cycle numbers come from the burst timing (3 cycles/byte, done at 3k+1).
module tb_regfile_reader;

  localparam int ADDR_W = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  logic [7:0] mem [8];

  int checks   = 0;
  int failures = 0;

  int byte_q [$];
  int rise_q [$];
  int addr_q [$];
  int done_cyc;
  int done_cnt;
  int rden_cnt;

  regfile_reader #(.ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .count     (count),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Synchronous read port with one cycle of latency.
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one start and monitor for up to 80 cycles; cycle c counts edges from the start edge.
  task automatic run_burst(input int b, input int n, input int stall_idx, input int stall_len);
    int c;
    int stall_left;
    bit pv;
    byte_q.delete(); rise_q.delete(); addr_q.delete();
    done_cyc = 0; done_cnt = 0; rden_cnt = 0;
    stall_left = stall_len;
    pv = 1'b0;
    c = 0;
    base  = ADDR_W'(b);
    count = (ADDR_W+1)'(n);
    start = 1'b1;
    out_ready = 1'b1;
    while (c < 80 && !(done_cnt > 0 && c >= done_cyc + 2)) begin
      tick();
      c++;
      start = 1'b0;
      if (rd_en) begin addr_q.push_back(int'(rd_addr)); rden_cnt++; end
      if (done) begin done_cyc = c; done_cnt++; end
      if (out_valid && !pv) rise_q.push_back(c);
      pv = out_valid;
      out_ready = 1'b1;
      if (out_valid) begin
        if (byte_q.size() == stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          check("stall_hold_out", int'(out), int'(mem[(b + stall_idx) % 8]));
        end else begin
          byte_q.push_back(int'(out));
        end
      end
    end
    out_ready = 1'b1;
    if (done_cnt == 0) check("burst_timeout", 0, 1);
  endtask

  // Compare captured burst against the timing model.
  task automatic verify_burst(input string name, input int b, input int n,
                              input int stall_idx, input int stall_len);
    int nb;
    int sum;
    int extra;
    int exp_done;
    sum = 0;
    extra = 0;
`ifdef REGFILE_READER_CHECKSUM_EN
    nb = n + 1;
`else
    nb = n;
`endif
    check({name, "_rden_cnt"}, rden_cnt, n);
    check({name, "_byte_cnt"}, byte_q.size(), nb);
    check({name, "_rise_cnt"}, rise_q.size(), nb);
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx + 1) extra = stall_len;
      sum = (sum + mem[(b + i) % 8]) % 256;
      if (i < addr_q.size()) check({name, "_rd_addr"}, addr_q[i], (b + i) % 8);
      if (i < byte_q.size()) check({name, "_byte"}, byte_q[i], int'(mem[(b + i) % 8]));
      if (i < rise_q.size()) check({name, "_rise_cyc"}, rise_q[i], 3 * (i + 1) + extra);
    end
    if (stall_idx < n) extra = stall_len;
    exp_done = 3 * n + 1 + extra;
`ifdef REGFILE_READER_CHECKSUM_EN
    if (n < byte_q.size()) check({name, "_checksum"}, byte_q[n], sum);
    if (n < rise_q.size()) check({name, "_sum_rise"}, rise_q[n], exp_done);
    exp_done++;
`endif
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_done_cyc"}, done_cyc, exp_done);
    check({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h80 + i);
    mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h33;
    mem[7] = 8'h77; mem[0] = 8'hF0; mem[1] = 8'h20;

    // Reset with start held: nothing may begin.
    reset = 1'b1; start = 1'b1; base = '0; count = 4'd3; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out", int'(out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0; start = 1'b0;
    repeat (2) tick();
    check("idle_busy", int'(busy), 0);
    check("idle_rd_en", int'(rd_en), 0);

    // Basic burst and the same burst with 5 stall cycles on the second byte.
    run_burst(2, 3, 99, 0);
    verify_burst("burst", 2, 3, 99, 0);
    run_burst(2, 3, 1, 5);
    verify_burst("stall", 2, 3, 1, 5);

    // Address wraps 7 -> 0 -> 1.
    run_burst(7, 3, 99, 0);
    verify_burst("wrap", 7, 3, 99, 0);

    // Two bytes whose sum exceeds 0xFF.
    run_burst(0, 2, 99, 0);
    verify_burst("pair", 0, 2, 99, 0);

    // Full-depth burst: count = 2^ADDR_W.
    run_burst(5, 8, 99, 0);
    verify_burst("full", 5, 8, 99, 0);

    // count = 0, with start re-asserted during the done cycle.
    base = 3'd4; count = '0; start = 1'b1;
    tick(); start = 1'b0;
`ifdef REGFILE_READER_CHECKSUM_EN
    check("zero_sum_valid", int'(out_valid), 1);
    check("zero_sum_byte", int'(out), 0);
    tick();
`endif
    check("zero_done", int'(done), 1);
    check("zero_rd_en", int'(rd_en), 0);
    start = 1'b1; count = 4'd2;
    tick(); start = 1'b0;
    check("fin_start_busy", int'(busy), 0);
    check("fin_start_done", int'(done), 0);
    tick();
    check("fin_start_rd_en", int'(rd_en), 0);
    check("fin_start_valid", int'(out_valid), 0);

    // Reset during SEND of byte 2 (cycle 6), then a normal burst.
    base = 3'd2; count = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    c = 1;
    while (c < 6) begin tick(); c++; end
    check("mid_send_valid", int'(out_valid), 1);
    check("mid_send_byte", int'(out), 8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out", int'(out), 0);
    done_cnt = 0;
    repeat (12) begin tick(); if (done || rd_en) done_cnt++; end
    check("mid_rst_quiet", done_cnt, 0);
    run_burst(2, 3, 99, 0);
    verify_burst("after_rst", 2, 3, 99, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
